// File: rtl/soc_system_pio_cmd_out.sv
// Avalon-MM command output PIO with a two-entry FIFO (output + holding register) and ready/valid
// handshake. Optional transfer counter is enabled by defining PIO_CMD_OUT_COUNT_EN.
module soc_system_pio_cmd_out #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  logic [DATA_WIDTH-1:0] out_port_q, out_port_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] last_word_q, last_word_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [15:0]           count_value;

  logic                  wr, data_wr, status_wr, xfer, ovf_event;
  logic [DATA_WIDTH-1:0] word;
  logic [31:0]           last_ext;

  assign wr        = chipselect && !write_n;
  assign data_wr   = wr && (address == AddrData);
  assign status_wr = wr && (address == AddrStatus);
  assign xfer      = out_valid_q && out_ready;
  assign word      = writedata[DATA_WIDTH-1:0];
  // Both entries occupied and nothing leaving: the incoming word has nowhere to go.
  assign ovf_event = data_wr && out_valid_q && hold_full_q && !xfer;

  always_comb begin
    out_port_d  = out_port_q;
    out_valid_d = out_valid_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_word_d = last_word_q;
    if (xfer) begin
      if (hold_full_q) begin
        out_port_d  = hold_q;
        hold_full_d = data_wr;
        if (data_wr) begin
          hold_d = word;
        end
      end else if (data_wr) begin
        out_port_d = word;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (data_wr) begin
      if (!out_valid_q) begin
        out_port_d  = word;
        out_valid_d = 1'b1;
      end else if (!hold_full_q) begin
        hold_d      = word;
        hold_full_d = 1'b1;
      end
    end
    if (data_wr && !ovf_event) begin
      last_word_d = word;
    end
    overflow_d = ovf_event || (overflow_q && !(status_wr && writedata[2]));
  end

  always_comb begin
    last_ext = '0;
    last_ext[DATA_WIDTH-1:0] = last_word_q;
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      AddrData:   readdata_d = last_ext;
      AddrStatus: readdata_d[2:0] = {overflow_q, hold_full_q, out_valid_q};
      AddrCount:  readdata_d[15:0] = count_value;
      default:    readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      last_word_q <= '0;
      readdata_q  <= '0;
    end else begin
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overflow_q  <= overflow_d;
      last_word_q <= last_word_d;
      readdata_q  <= readdata_d;
    end
  end

`ifdef PIO_CMD_OUT_COUNT_EN
  logic [15:0] count_q, count_d;
  logic        count_wr;

  assign count_wr = wr && (address == AddrCount);

  // A clear and a transfer in the same cycle leave the count at one.
  always_comb begin
    count_d = count_wr ? 16'h0000 : count_q;
    if (xfer) begin
      count_d = count_d + 16'h0001;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_value = count_q;
`else
  assign count_value = 16'h0000;
`endif

  assign readdata  = readdata_q;
  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/soc_system_pio_cmd_out.md
SOC_SYSTEM_PIO_CMD_OUT -- requirements
Module: soc_system_pio_cmd_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of out_port and of the command word taken from writedata[DATA_WIDTH-1:0]; legal range 1..32.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port address, input, 2: Avalon-MM register select.
REQ-005 SHALL have port chipselect, input, 1: slave select; qualifies write_n.
REQ-006 SHALL have port write_n, input, 1: active-low write strobe.
REQ-007 SHALL have port writedata, input, 32: write data.
REQ-008 SHALL have port readdata, output, 32: registered read data.
REQ-009 SHALL have port out_port, output, DATA_WIDTH: command word presented to fabric logic.
REQ-010 SHALL have port out_valid, output, 1: out_port holds an unconsumed command.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_port this cycle.

Function
REQ-012 A write SHALL be chipselect=1 and write_n=0 in a cycle; it takes effect at that clock edge.
REQ-013 Register map SHALL be: 0 DATA, 1 STATUS, 2 COUNT, 3 reserved (reads 0, writes ignored).
REQ-014 readdata SHALL update every cycle from the address presented in the previous cycle (1-cycle read latency, no read strobe); unused upper bits read 0.
REQ-015 DATA read SHALL return the last word accepted into the buffer; STATUS read SHALL return bit0=out_valid, bit1=hold_full, bit2=overflow, others 0.
REQ-016 Buffer SHALL be two entries: output register (out_port/out_valid) and one holding register (hold_full).
REQ-017 A transfer SHALL occur in a cycle with out_valid=1 and out_ready=1; out_port SHALL stay stable while out_valid=1 and no transfer occurs.
REQ-018 DATA write, output empty: word SHALL load out_port with out_valid=1 on the next cycle (latency 1).
REQ-019 DATA write, output full, holding empty, no transfer: word SHALL load the holding register.
REQ-020 On transfer with holding full: holding SHALL move to out_port, out_valid stays 1, hold_full clears unless a simultaneous DATA write refills it.
REQ-021 On transfer with holding empty: a simultaneous DATA write SHALL load out_port directly (out_valid stays 1); otherwise out_valid SHALL fall to 0.
REQ-022 DATA write with both entries full and no transfer SHALL be discarded and SHALL set sticky overflow; order of accepted words SHALL be preserved FIFO.
REQ-023 STATUS write with writedata[2]=1 SHALL clear overflow; a simultaneous overflow event SHALL take priority (overflow stays 1).

Reset
REQ-024 While reset=1: out_valid=0, hold_full=0, overflow=0, out_port=0, holding register=0, last-word register=0, readdata=0, COUNT=0, asynchronously.
REQ-025 Reset asserted mid-handshake SHALL discard both buffered words without a transfer; out_ready is ignored during reset.

Configuration
REQ-026 Macro PIO_CMD_OUT_COUNT_EN defined: COUNT SHALL be a 16-bit counter of completed transfers in readdata[15:0], wrapping 0xFFFF->0x0000; any write to COUNT clears it, a simultaneous transfer then leaves it at 1.
REQ-027 Macro PIO_CMD_OUT_COUNT_EN undefined: no counter logic; COUNT reads 0, writes ignored.

Verification
REQ-028 Reset, write DATA=0x12345678 with out_ready=0 -> next cycle out_valid=1, out_port=0x12345678; STATUS reads 0x1.
REQ-029 out_ready=0, write 0xA, 0xB, 0xC -> STATUS reads 0x7, 0xC lost; raise out_ready -> out_port shows 0xA then 0xB on consecutive cycles, then out_valid=0.
REQ-030 Both full, DATA write 0xD in the same cycle as a transfer -> no overflow; subsequent outputs 0xB then 0xD.
REQ-031 overflow set, STATUS write 0x4 -> STATUS bit2 reads 0; repeat with concurrent overflow -> bit2 stays 1.
REQ-032 With PIO_CMD_OUT_COUNT_EN: 3 transfers -> COUNT=3; preload via 0xFFFF transfers -> next transfer gives 0; without macro COUNT reads 0.
REQ-033 Assert reset while out_valid=1 and hold_full=1 -> out_valid=0, STATUS=0 immediately; no transfer observed after release.
